// File: rtl/program_launcher_pkg.sv
// Shared program codes and launcher FSM encoding.
// The regfile program-copy logic decodes the same codes.
package program_launcher_pkg;

    localparam int unsigned SEL_W   = 32;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned NUM_BTN = 5;

    // Bit positions of each button in the conditioned button vectors
    localparam int unsigned BTN_FIB   = 0;
    localparam int unsigned BTN_SORT  = 1;
    localparam int unsigned BTN_SAVE  = 2;
    localparam int unsigned BTN_LOAD  = 3;
    localparam int unsigned BTN_PUSHA = 4;

    typedef enum logic [CODE_W-1:0] {
        PROG_NONE  = 3'd0,
        PROG_FIB   = 3'd1,
        PROG_SORT  = 3'd2,
        PROG_SAVE  = 3'd3,
        PROG_LOAD  = 3'd4,
        PROG_PUSHA = 3'd5
    } prog_code_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } launch_state_e;

    // Highest-priority program among simultaneous presses: fib > sort > save > load > pusha
    function automatic prog_code_e pick_code(input logic [NUM_BTN-1:0] rise);
        if (rise[BTN_FIB]) begin
            return PROG_FIB;
        end else if (rise[BTN_SORT]) begin
            return PROG_SORT;
        end else if (rise[BTN_SAVE]) begin
            return PROG_SAVE;
        end else if (rise[BTN_LOAD]) begin
            return PROG_LOAD;
        end else if (rise[BTN_PUSHA]) begin
            return PROG_PUSHA;
        end
        return PROG_NONE;
    endfunction

endpackage

// File: rtl/program_launcher_button_conditioner.sv
// Synchroniser, debouncer and press (rising-edge) detector for one raw button.
// The debounced value flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 650000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic debounced,
    output logic rise_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync;
    logic             debounced_q;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta   <= 1'b0;
            sync        <= 1'b0;
            debounced   <= 1'b0;
            debounced_q <= 1'b0;
            count       <= '0;
        end else begin
            sync_meta   <= raw;
            sync        <= sync_meta;
            debounced_q <= debounced;
            if (sync == debounced) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                debounced <= ~debounced;
                count     <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign rise_c = debounced & ~debounced_q;

endmodule

// File: rtl/program_launcher.sv
// Turns debounced button presses into one fixed-length program_selector window per press.
// Presses arriving while a window is active or buttons are still held are dropped.
module program_launcher
    import program_launcher_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 650000,
    parameter int unsigned HOLD_CYCLES     = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_fib,
    input  logic             btn_sort,
    input  logic             btn_save,
    input  logic             btn_load,
    input  logic             btn_pusha,
    output logic [SEL_W-1:0] program_selector,
    output logic             launch,
    output logic             busy
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] debounced;
    logic [NUM_BTN-1:0] rise;
    logic               any_rise_c;
    logic               any_held_c;

    launch_state_e      state;
    launch_state_e      state_next;
    logic [HOLD_W-1:0]  hold_count;
    logic [HOLD_W-1:0]  hold_count_next;
    logic [SEL_W-1:0]   selector_next;
    logic               launch_next;

    assign raw[BTN_FIB]   = btn_fib;
    assign raw[BTN_SORT]  = btn_sort;
    assign raw[BTN_SAVE]  = btn_save;
    assign raw[BTN_LOAD]  = btn_load;
    assign raw[BTN_PUSHA] = btn_pusha;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .clock    (clock),
            .reset    (reset),
            .raw      (raw[i]),
            .debounced(debounced[i]),
            .rise_c   (rise[i])
        );
    end

    assign any_rise_c = |rise;
    assign any_held_c = |debounced;

    // State register, including the registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            hold_count       <= '0;
            program_selector <= '0;
            launch           <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state            <= state_next;
            hold_count       <= hold_count_next;
            program_selector <= selector_next;
            launch           <= launch_next;
            busy             <= (state_next != IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_next      = state;
        hold_count_next = hold_count;
        unique case (state)
            IDLE: begin
                if (any_rise_c) begin
                    state_next      = HOLD;
                    hold_count_next = HOLD_LAST;
                end
            end
            HOLD: begin
                if (hold_count == '0) begin
                    state_next = any_held_c ? RELEASE : IDLE;
                end else begin
                    hold_count_next = hold_count - HOLD_W'(1);
                end
            end
            RELEASE: begin
                if (!any_held_c) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: selector keeps its code until the hold counter expires
    always_comb begin
        selector_next = '0;
        launch_next   = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_rise_c) begin
                    selector_next = SEL_W'(pick_code(rise));
                    launch_next   = 1'b1;
                end
            end
            HOLD: begin
                if (hold_count != '0) begin
                    selector_next = program_selector;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_program_launcher.sv
// Bench for program_launcher: directed plan scenarios plus random button activity,
// checked cycle by cycle against a sliding-window reference model through a scoreboard.
module tb_program_launcher;

    localparam int unsigned D    = 4;
    localparam int unsigned H    = 3;
    localparam int unsigned NB   = 5;
    localparam int          MAXC = 8192;

    typedef struct packed {
        logic [31:0] sel;
        logic        launch;
        logic        busy;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic [NB-1:0] btn;
    logic [31:0]   program_selector;
    logic          launch;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;
    int launch_count = 0;

    program_launcher #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .btn_fib         (btn[0]),
        .btn_sort        (btn[1]),
        .btn_save        (btn[2]),
        .btn_load        (btn[3]),
        .btn_pusha       (btn[4]),
        .program_selector(program_selector),
        .launch          (launch),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    // Reference model: raw samples, synchronised samples and debounced value per edge
    bit   rh [NB][MAXC];
    bit   sh [NB][MAXC];
    bit   db [NB][MAXC];
    int   cyc = 8;
    bit   m_idle = 1'b1;
    int   m_launch_edge = 0;
    int   m_code = 0;
    exp_t exp_q[$];
    int   code_q[$];

    always @(posedge clock) begin
        exp_t          e;
        logic [NB-1:0] r;
        bit            held;
        bit            stable;
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL model_budget: edge %0d exceeds model capacity %0d", cyc, MAXC);
            $fatal(1);
        end
        e    = '0;
        r    = '0;
        held = 1'b0;
        if (reset) begin
            for (int b = 0; b < NB; b++) begin
                for (int k = cyc - int'(D); k <= cyc; k++) begin
                    rh[b][k] = 1'b0;
                    sh[b][k] = 1'b0;
                end
                db[b][cyc] = 1'b0;
            end
            m_idle = 1'b1;
        end else begin
            for (int b = 0; b < NB; b++) begin
                sh[b][cyc] = rh[b][cyc-2];
                rh[b][cyc] = btn[b];
                // Flip only when the last D synchronised samples all disagree
                stable = 1'b1;
                for (int k = 0; k < int'(D); k++)
                    if (sh[b][cyc-k] == db[b][cyc-1]) stable = 1'b0;
                db[b][cyc] = stable ? ~db[b][cyc-1] : db[b][cyc-1];
                r[b] = db[b][cyc-1] & ~db[b][cyc-2];
                held = held | db[b][cyc-1];
            end
            if (m_idle) begin
                if (r != '0) begin
                    m_code = 0;
                    for (int b = NB - 1; b >= 0; b--)
                        if (r[b]) m_code = b + 1;
                    m_idle        = 1'b0;
                    m_launch_edge = cyc;
                    e.sel         = 32'(m_code);
                    e.launch      = 1'b1;
                    e.busy        = 1'b1;
                    code_q.push_back(m_code);
                end
            end else if (cyc - m_launch_edge < int'(H)) begin
                e.sel  = 32'(m_code);
                e.busy = 1'b1;
            end else begin
                m_idle = !held;
                e.busy = held;
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: per-cycle output compare plus launch-event scoreboard
    always @(negedge clock) begin
        exp_t e;
        int   c;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({program_selector, launch, busy} !== e) begin
                miscompares++;
                $display("FAIL cycle_outputs @%0t: sel=%0d launch=%b busy=%b, expected sel=%0d launch=%b busy=%b",
                         $time, program_selector, launch, busy, e.sel, e.launch, e.busy);
            end
        end
        if (launch === 1'b1) begin
            launch_count++;
            vectors++;
            if (code_q.size() == 0) begin
                miscompares++;
                $display("FAIL launch_event @%0t: launch with sel=%0d, expected no launch", $time, program_selector);
            end else begin
                c = code_q.pop_front();
                if (program_selector !== 32'(c)) begin
                    miscompares++;
                    $display("FAIL launch_code @%0t: sel=%0d, expected %0d", $time, program_selector, c);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    int base;

    initial begin
        reset = 1'b1;
        btn   = '0;
        step(3);
        check("reset_sel", program_selector, 0);
        check("reset_launch", 32'(launch), 0);
        check("reset_busy", 32'(busy), 0);
        reset = 1'b0;
        step(2);

        // Single fib press held 20 cycles
        base = launch_count;
        btn[0] = 1'b1;
        step(6);
        check("fib_edge6_launch", 32'(launch), 0);
        step(1);
        check("fib_edge7_sel", program_selector, 1);
        check("fib_edge7_launch", 32'(launch), 1);
        step(2);
        check("fib_edge9_sel", program_selector, 1);
        check("fib_edge9_launch", 32'(launch), 0);
        step(1);
        check("fib_edge10_sel", program_selector, 0);
        check("fib_edge10_busy", 32'(busy), 1);
        step(10);
        btn[0] = 1'b0;
        step(12);
        check("fib_idle_busy", 32'(busy), 0);
        check("fib_launches", 32'(launch_count - base), 1);

        // Three-cycle glitch on sort
        base = launch_count;
        btn[1] = 1'b1;
        step(3);
        btn[1] = 1'b0;
        step(12);
        check("glitch_launches", 32'(launch_count - base), 0);

        // save and load together: save wins
        base = launch_count;
        btn[2] = 1'b1;
        btn[3] = 1'b1;
        step(7);
        check("save_load_sel", program_selector, 3);
        step(2);
        check("save_load_sel_last", program_selector, 3);
        step(1);
        check("save_load_sel_end", program_selector, 0);
        step(3);
        btn = '0;
        step(12);
        check("save_load_launches", 32'(launch_count - base), 1);

        // sort pressed during a fib window is dropped; then a fresh pusha
        base = launch_count;
        btn[0] = 1'b1;
        step(7);
        check("fib_sort_sel", program_selector, 1);
        btn[1] = 1'b1;
        step(12);
        btn = '0;
        step(15);
        check("fib_sort_launches", 32'(launch_count - base), 1);
        btn[4] = 1'b1;
        step(7);
        check("pusha_sel", program_selector, 5);
        btn = '0;
        step(12);

        // Reset in the second HOLD cycle, sort kept held
        base = launch_count;
        btn[1] = 1'b1;
        step(7);
        check("sort_sel", program_selector, 2);
        step(1);
        reset = 1'b1;
        step(1);
        check("midhold_reset_sel", program_selector, 0);
        check("midhold_reset_busy", 32'(busy), 0);
        reset = 1'b0;
        step(6);
        check("relaunch_early", 32'(launch), 0);
        step(1);
        check("relaunch_launch", 32'(launch), 1);
        check("relaunch_sel", program_selector, 2);
        btn = '0;
        step(15);
        check("reset_launches", 32'(launch_count - base), 2);

        // Bouncing load, then steady high
        base = launch_count;
        for (int i = 0; i < 5; i++) begin
            btn[3] = ~btn[3];
            step(2);
        end
        step(4);
        check("bounce_early", 32'(launch), 0);
        step(1);
        check("bounce_launch", 32'(launch), 1);
        check("bounce_sel", program_selector, 4);
        btn = '0;
        step(15);
        check("bounce_launches", 32'(launch_count - base), 1);

        // Random button activity with occasional resets
        for (int i = 0; i < 120; i++) begin
            btn = NB'($urandom_range(0, 31) & $urandom_range(0, 31));
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                step(1);
                reset = 1'b0;
            end
            step($urandom_range(1, 12));
        end
        btn = '0;
        step(25);
        check("pending_launches", 32'(code_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/program_launcher.md
Name: program_launcher

Overview:
Front-end stage between the raw board buttons and the processor's program_selector input of the regfile. It synchronises and debounces each program button and detects presses. It converts one press into a fixed-length, single-program selector window, so the program-copy logic always sees a clean code for exactly HOLD_CYCLES cycles. It replaces the direct button-to-selector priority logic and guarantees one launch per press.

Parameters:
DEBOUNCE_CYCLES, 650000, consecutive cycles a synchronised button must differ from its debounced value before the debounced value flips (min 1)
HOLD_CYCLES, 4, cycles the selected program code is driven on program_selector per launch (min 1)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_fib  input  1  raw button, program 1
btn_sort  input  1  raw button, program 2
btn_save  input  1  raw button, program 3
btn_load  input  1  raw button, program 4
btn_pusha  input  1  raw button, program 5
program_selector  output  32  program code to regfile; 0 = none
launch  output  1  one-cycle pulse on the first cycle program_selector is non-zero
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: program_selector=0, launch=0, busy=0, state=IDLE, all sync flops, debounced values and counters cleared to 0.
- Per button, in order: 2-flop synchroniser, then debounce counter.
  - Counter clears when sync == debounced.
  - Otherwise it increments.
  - When sync != debounced and counter == DEBOUNCE_CYCLES-1, debounced flips and counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never flips debounced.
- rise[i] = debounced[i] & ~debounced_q[i] (debounced_q is a registered copy).
- Latency: raw held high from sampling edge 1 gives debounced high after edge D+2. program_selector and launch change on edge D+3.
- Priority when several rises occur in the same cycle: fib > sort > save > load > pusha. Codes are 1,2,3,4,5, zero-extended to 32 bits.
- FSM:
  - IDLE: on any rise, load the code of the highest-priority rise, set launch=1, hold counter=HOLD_CYCLES-1, go to HOLD. Otherwise selector=0.
  - HOLD: launch=0 and selector held. Decrement each cycle. On the cycle the counter is 0, the next edge sets selector=0 and goes to RELEASE if any debounced button is high, else IDLE.
  - RELEASE: selector=0. Go to IDLE on the first cycle all debounced buttons are low.
- Rises occurring in HOLD or RELEASE are discarded and never queued.
- Selector is non-zero for exactly HOLD_CYCLES consecutive cycles per launch.
- Reset asserted mid-HOLD: the next edge zeroes the selector and returns to IDLE.
- A button held through reset deassertion launches once, D+3 cycles after reset drops (its debounced value restarts from 0).
- HOLD_CYCLES=1: a single-cycle selector with launch on the same cycle.
- Counter widths: $clog2(DEBOUNCE_CYCLES+1) and $clog2(HOLD_CYCLES+1). No wrap is possible.

Decomposition:
- Shared package: program code constants (PROG_NONE=0, PROG_FIB=1, PROG_SORT=2, PROG_SAVE=3, PROG_LOAD=4, PROG_PUSHA=5) and the FSM state encoding (IDLE, HOLD, RELEASE). The regfile program-copy logic reuses the same codes.
- One sub-module, button_conditioner: synchroniser, debouncer and rise detector, parameterised by DEBOUNCE_CYCLES and instantiated five times.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=3.
- Raw btn_fib high from edge 1 and held 20 cycles -> selector=1 and launch=1 at edge 7. Selector=1 through edge 9, 0 at edge 10. State RELEASE until release is debounced, then IDLE. Exactly one launch.
- btn_sort pulses high for 3 cycles (glitch) -> selector stays 0, launch never asserts, busy stays 0.
- btn_save and btn_load rise on the same edge -> selector=3 for 3 cycles; code 4 never appears.
- btn_fib pressed; btn_sort pressed while selector=1 -> sort is ignored, no second launch. After all buttons are released, a fresh btn_pusha press gives selector=5.
- reset asserted on the second HOLD cycle of a sort launch -> selector=0 and busy=0 on the next edge. With btn_sort still held, relaunch occurs 7 cycles after reset deasserts.
- Bouncing btn_load (toggle every 2 cycles for 10 cycles, then steady high) -> exactly one launch with selector=4, 7 cycles after the last toggle.
